// File: rtl/prog_datapath_if.sv
// Program-memory and control bus for prog_datapath.
//   start       : resume pulse from the controller, honoured only while halted
//   instr_addr  : program counter driven to the external program memory (async read)
//   instr_data  : instruction word returned by the memory, {opcode[3:0], imm[WIDTH-1:0]}
//   halted      : high while the datapath sits in its halted state
// The master modport is the memory/controller side; the slave modport is the datapath.
interface prog_datapath_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PC_W  = 4
);
    logic               start;
    logic [PC_W-1:0]    instr_addr;
    logic [WIDTH+3:0]   instr_data;
    logic               halted;

    modport master (
        output start,
        output instr_data,
        input  instr_addr,
        input  halted
    );

    modport slave (
        input  start,
        input  instr_data,
        output instr_addr,
        output halted
    );
endinterface

// File: rtl/prog_datapath.sv
// Small programmable datapath: a two-cycle FETCH/EXEC machine with three WIDTH-bit
// registers (X, Y, Z), a 4-bit-opcode ALU and registered {v,c,z} flags.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : program bus (start, instr_addr, instr_data, halted), slave side
//   out_x/y/z  : register contents
//   out_alu    : combinational ALU result for the opcode in IR (X for non-ALU opcodes)
//   flags      : registered {v, c, z}
//   opcode     : opcode field of IR
module prog_datapath #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PC_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_datapath_if.slave     bus,
    output logic [WIDTH-1:0]   out_x,
    output logic [WIDTH-1:0]   out_y,
    output logic [WIDTH-1:0]   out_z,
    output logic [WIDTH-1:0]   out_alu,
    output logic [2:0]         flags,
    output logic [3:0]         opcode
);

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLdx  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpMvz  = 4'h7;
    localparam logic [3:0] OpClrx = 4'h8;
    localparam logic [3:0] OpClry = 4'h9;
    localparam logic [3:0] OpClrz = 4'hA;
    localparam logic [3:0] OpShry = 4'hB;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpJz   = 4'hD;
    localparam logic [3:0] OpHalt = 4'hE;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalted
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [WIDTH+3:0]   ir_q, ir_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic [2:0]         flags_q, flags_d;   // {v, c, z}

    logic [3:0]         op;
    logic [WIDTH-1:0]   imm;
    logic [PC_W-1:0]    jmp_tgt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_z;
    logic               alu_upd;

    assign op  = ir_q[WIDTH+3:WIDTH];
    assign imm = ir_q[WIDTH-1:0];

    // Jump target: truncate a wide immediate, zero-extend a narrow one.
    if (WIDTH >= PC_W) begin : g_tgt_trunc
        assign jmp_tgt = imm[PC_W-1:0];
    end else begin : g_tgt_zext
        assign jmp_tgt = {{(PC_W - WIDTH){1'b0}}, imm};
    end

    // One extra bit captures carry-out of the add and borrow of the subtract.
    assign sum  = {1'b0, x_q} + {1'b0, y_q};
    assign diff = {1'b0, x_q} - {1'b0, y_q};

    always_comb begin
        alu_res = x_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b0;
        case (op)
            OpAdd: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
                alu_upd = 1'b1;
            end
            OpSub: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (diff[WIDTH-1] != x_q[WIDTH-1]);
                alu_upd = 1'b1;
            end
            OpAnd: begin
                alu_res = x_q & y_q;
                alu_upd = 1'b1;
            end
            OpOr: begin
                alu_res = x_q | y_q;
                alu_upd = 1'b1;
            end
            OpXor: begin
                alu_res = x_q ^ y_q;
                alu_upd = 1'b1;
            end
            OpShry: begin
                alu_res = y_q >> 1;
                alu_c   = y_q[0];
                alu_upd = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_z = (alu_res == '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        flags_d = flags_q;
        unique case (state_q)
            StFetch: begin
                ir_d    = bus.instr_data;
                state_d = StExec;
            end
            StExec: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = StFetch;
                if (alu_upd) begin
                    y_d     = alu_res;
                    flags_d = {alu_v, alu_c, alu_z};
                end
                case (op)
                    OpNop:  ;
                    OpLdx:  x_d = imm;
                    OpMvz:  z_d = y_q;
                    OpClrx: x_d = '0;
                    OpClry: y_d = '0;
                    OpClrz: z_d = '0;
                    OpJmp:  pc_d = jmp_tgt;
                    // z as registered before this EXEC cycle
                    OpJz:   if (flags_q[0]) pc_d = jmp_tgt;
                    OpHalt: state_d = StHalted;
                    default: ;
                endcase
            end
            StHalted: begin
                if (bus.start) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            flags_q <= flags_d;
        end
    end

    assign bus.instr_addr = pc_q;
    assign bus.halted     = (state_q == StHalted);
    assign out_x          = x_q;
    assign out_y          = y_q;
    assign out_z          = z_q;
    assign out_alu        = alu_res;
    assign flags          = flags_q;
    assign opcode         = op;

endmodule

// File: doc/prog_datapath.md
PROG_DATAPATH -- requirements
Module: prog_datapath

Interface
REQ-001 Parameter WIDTH, default 4, sets the width of the X, Y and Z registers, the ALU and the immediate field; the legal range is >=2.
REQ-002 Parameter PC_W, default 4, sets the program-counter width; program depth is 2^PC_W words.
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port start  in  1  resume pulse, honoured only in HALTED.
REQ-006 Port instr_addr  out  PC_W  equals PC; the external program memory reads it asynchronously.
REQ-007 Port instr_data  in  4+WIDTH  instruction word; [WIDTH+3:WIDTH] is the opcode and [WIDTH-1:0] is imm.
REQ-008 Ports out_x, out_y, out_z  out  WIDTH  register contents.
REQ-009 Port out_alu  out  WIDTH  combinational ALU result for the opcode held in IR.
REQ-010 Port flags  out  3  registered {v,c,z}.
REQ-011 Port opcode  out  4  IR opcode.
REQ-012 Port halted  out  1  high while the FSM is in HALTED.

Function
REQ-013 The FSM SHALL have three states: FETCH, EXEC and HALTED. FETCH latches instr_data into IR and moves to EXEC. EXEC performs the operation and moves to FETCH, or to HALTED on HALT.
REQ-014 Every instruction SHALL take exactly 2 cycles.
REQ-015 In EXEC, PC SHALL become PC+1 modulo 2^PC_W, except on a taken jump.
REQ-016 ALU operands SHALL be A=X and B=Y, and the result SHALL be truncated to WIDTH bits.
REQ-017 Opcodes 0-7 SHALL behave as follows: 0 NOP; 1 LDX: X<=imm; 2 ADD: Y<=X+Y; 3 SUB: Y<=X-Y; 4 AND: Y<=X&Y; 5 OR: Y<=X|Y; 6 XOR: Y<=X^Y; 7 MVZ: Z<=Y.
REQ-018 Opcodes 8-F SHALL behave as follows: 8 CLRX; 9 CLRY; A CLRZ; B SHRY: Y<=Y>>1 with zero fill; C JMP: PC<=imm; D JZ: PC<=imm if flag z=1, else PC+1; E HALT; F is reserved and executes as NOP.
REQ-019 Jump targets SHALL be imm[PC_W-1:0] when WIDTH>=PC_W, otherwise imm zero-extended to PC_W bits.
REQ-020 Flags SHALL update only in EXEC of ADD, SUB, AND, OR, XOR and SHRY; all other opcodes hold the flags.
REQ-021 z SHALL be set when the WIDTH-bit result is 0.
REQ-022 For ADD, c SHALL be the carry-out and v the signed overflow.
REQ-023 For SUB, c SHALL be the borrow (1 iff X<Y unsigned) and v the signed overflow of X-Y.
REQ-024 For AND, OR and XOR, c and v SHALL be 0.
REQ-025 For SHRY, c SHALL be the old Y[0] and v SHALL be 0.
REQ-026 JZ SHALL test the flag z value registered before its EXEC cycle.
REQ-027 HALT SHALL increment PC, then enter HALTED; in HALTED all registers, flags and PC hold.
REQ-028 A start pulse in HALTED SHALL move the FSM to FETCH on the next edge, resuming at the already-incremented PC; start is ignored in FETCH and EXEC.
REQ-029 PC SHALL wrap from 2^PC_W-1 to 0 with no fault indication.
REQ-030 out_alu SHALL be valid for ALU opcodes and SHALL equal X for all other opcodes.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force the FSM to FETCH, PC=0, IR=0 and X=Y=Z=0.
REQ-032 While rst_n=0, flags SHALL be 0, halted SHALL be 0 and opcode SHALL be 0.
REQ-033 Reset asserted mid-instruction SHALL abort that instruction with no partial register write.
REQ-034 After release, the first FETCH SHALL occur on the first rising edge.

Verification (WIDTH=4, PC_W=4)
REQ-035 Program LDX 5; ADD; MVZ; HALT with Y=0 -> after 8 cycles out_y=5, out_z=5, flags=000, halted=1, instr_addr=4.
REQ-036 Program LDX 9; ADD; ADD -> out_y=2 (9+9=18 mod 16), flags c=1, v=1 (9+9 overflows signed), z=0.
REQ-037 Program LDX 3; SUB with Y=3; JZ 0xA -> z=1 and instr_addr=0xA at the next FETCH; repeat with Y=2 -> z=0 and instr_addr advances to 3.
REQ-038 Program with JMP 0xF, then NOP at address 0xF -> PC wraps to 0 on the following EXEC.
REQ-039 In HALTED, start held low for 10 cycles -> all outputs are stable; one start pulse -> FETCH at the stored PC; start asserted during EXEC has no effect.
REQ-040 rst_n pulsed low mid-EXEC of LDX 7 -> X=0 and PC=0 immediately, without waiting for a clock edge; on release execution restarts at address 0.
